led_driver_rx: RTL and testbench

Receive-side decoder for the LED-driver serial bus (SCLK/LAT/SIN) that the synchronizer and data path drive. It oversamples the bus in the system clock domain, shifts in data words, and decodes each LAT pulse into a driver command by counting SCLK rising edges while LAT is high. It sits on the FPGA as a loopback monitor on the driver pins, and in benches as the synthesizable driver model. It reports protocol violations as sticky error flags.

---
 rtl/led_driver_pkg.sv | 31 +++
 rtl/bit_sync.sv | 37 +++
 rtl/led_driver_rx.sv | 102 ++++++++++
 tb/tb_led_driver_rx.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/led_driver_pkg.sv
// led_driver_pkg: command codes and shared constants for the LED-driver serial bus.
package led_driver_pkg;

    typedef enum logic [3:0] {
        CMD_WRTGS     = 4'd1,
        CMD_LATGS     = 4'd3,
        CMD_WRTFC     = 4'd5,
        CMD_LINERESET = 4'd7,
        CMD_READFC    = 4'd11,
        CMD_TMGRST    = 4'd13,
        CMD_FCWRTEN   = 4'd15
    } led_cmd_t;

    localparam int SR_WIDTH_DEFAULT = 48;
    localparam logic [3:0] LAT_CNT_MAX = 4'd15;
    localparam logic [5:0] BIT_CNT_MAX = 6'd63;

    localparam int EDGE_NONE = 0;
    localparam int EDGE_RISE = 1;
    localparam int EDGE_FALL = 2;

    function automatic logic cmd_known(input logic [3:0] c);
        return c == CMD_WRTGS || c == CMD_LATGS || c == CMD_WRTFC || c == CMD_LINERESET ||
               c == CMD_READFC || c == CMD_TMGRST || c == CMD_FCWRTEN;
    endfunction

    function automatic logic cmd_has_data(input logic [3:0] c);
        return c == CMD_WRTGS || c == CMD_LATGS || c == CMD_WRTFC;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// bit_sync: two-flop synchroniser with an optional rising or falling edge pulse.
module bit_sync
    import led_driver_pkg::*;
#(
    parameter int EDGE = EDGE_NONE
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic pulse
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

    if (EDGE == EDGE_NONE) begin : g_none
        assign pulse = 1'b0;
    end else begin : g_edge
        logic prev;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) prev <= 1'b0;
            else      prev <= q;
        end
        assign pulse = (EDGE == EDGE_RISE) ? (q & ~prev) : (~q & prev);
    end

endmodule

// File: rtl/led_driver_rx.sv
// led_driver_rx: oversampling decoder for the SCLK/LAT/SIN LED-driver bus.
// Each LAT pulse becomes one command whose code is the number of SCLK rises seen while LAT was high.
module led_driver_rx
    import led_driver_pkg::*;
#(
    parameter int SR_WIDTH          = SR_WIDTH_DEFAULT,
    parameter int NB_LEDS_PER_GROUP = 16,
    localparam int LED_WIDTH        = $clog2(NB_LEDS_PER_GROUP)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SCLK,
    input  logic                 LAT,
    input  logic                 SIN,
    output logic                 cmd_valid,
    output logic [3:0]           cmd,
    output logic [SR_WIDTH-1:0]  cmd_data,
    output logic [LED_WIDTH-1:0] gs_index,
    output logic [SR_WIDTH-1:0]  fc_data,
    output logic                 bit_err,
    output logic                 seq_err,
    output logic                 fc_err,
    output logic                 cmd_err
);

    localparam logic [LED_WIDTH-1:0] GS_LAST  = LED_WIDTH'(NB_LEDS_PER_GROUP - 1);
    localparam logic [5:0]           BITS_REQ = 6'(SR_WIDTH);

    logic sclk_lvl_unused, sclk_rise;
    logic lat_s, lat_fall;
    logic sin_s, sin_pulse_unused;

    bit_sync #(.EDGE(EDGE_RISE)) u_sclk (
        .clk(clk), .rst(rst), .d(SCLK), .q(sclk_lvl_unused), .pulse(sclk_rise));
    bit_sync #(.EDGE(EDGE_FALL)) u_lat (
        .clk(clk), .rst(rst), .d(LAT), .q(lat_s), .pulse(lat_fall));
    bit_sync #(.EDGE(EDGE_NONE)) u_sin (
        .clk(clk), .rst(rst), .d(SIN), .q(sin_s), .pulse(sin_pulse_unused));

    logic [SR_WIDTH-1:0]  sr, sr_nxt;
    logic [5:0]           bit_cnt, bit_nxt;
    logic [3:0]           lat_cnt, lat_nxt;
    logic [LED_WIDTH-1:0] gs_cnt;
    logic                 fc_en;
    logic                 gs_at_last;

    // A LAT fall sampled together with an SCLK rise still counts that edge as LAT-high.
    always_comb begin
        sr_nxt     = sclk_rise ? {sr[SR_WIDTH-2:0], sin_s} : sr;
        bit_nxt    = (sclk_rise && bit_cnt != BIT_CNT_MAX) ? bit_cnt + 6'd1 : bit_cnt;
        lat_nxt    = (sclk_rise && (lat_s || lat_fall) && lat_cnt != LAT_CNT_MAX) ? lat_cnt + 4'd1 : lat_cnt;
        gs_at_last = gs_cnt == GS_LAST;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr        <= '0;
            bit_cnt   <= '0;
            lat_cnt   <= '0;
            gs_cnt    <= '0;
            fc_en     <= 1'b0;
            cmd_valid <= 1'b0;
            cmd       <= '0;
            cmd_data  <= '0;
            gs_index  <= '0;
            fc_data   <= '0;
            bit_err   <= 1'b0;
            seq_err   <= 1'b0;
            fc_err    <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            cmd_valid <= lat_fall;
            sr        <= sr_nxt;
            bit_cnt   <= lat_fall ? '0 : bit_nxt;
            lat_cnt   <= lat_fall ? '0 : lat_nxt;
            if (lat_fall) begin
                cmd      <= lat_nxt;
                cmd_data <= sr_nxt;
                fc_en    <= lat_nxt == CMD_FCWRTEN;
                if (!cmd_known(lat_nxt)) cmd_err <= 1'b1;
                if (cmd_has_data(lat_nxt) && bit_nxt != BITS_REQ) bit_err <= 1'b1;
                if (lat_nxt == CMD_WRTFC) begin
                    if (fc_en) fc_data <= sr_nxt;
                    else       fc_err  <= 1'b1;
                end
                // A WRTGS past the last data slot restarts the frame at channel 0.
                if (lat_nxt == CMD_WRTGS) begin
                    gs_index <= gs_at_last ? '0 : gs_cnt;
                    gs_cnt   <= gs_at_last ? LED_WIDTH'(1) : gs_cnt + LED_WIDTH'(1);
                    if (gs_at_last) seq_err <= 1'b1;
                end
                if (lat_nxt == CMD_LATGS) begin
                    gs_index <= GS_LAST;
                    gs_cnt   <= '0;
                    if (!gs_at_last) seq_err <= 1'b1;
                end
                if (lat_nxt == CMD_LINERESET) gs_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_led_driver_rx.sv
// tb_led_driver_rx: randomized scoreboard bench for led_driver_rx against a word-level model.
module tb_led_driver_rx;

    logic        clk = 1'b0, rst = 1'b0, SCLK = 1'b0, LAT = 1'b0, SIN = 1'b0;
    logic        cmd_valid, bit_err, seq_err, fc_err, cmd_err;
    logic [3:0]  cmd, gs_index;
    logic [47:0] cmd_data, fc_data;

    led_driver_rx #(.SR_WIDTH(48), .NB_LEDS_PER_GROUP(16)) dut (
        .clk(clk), .rst(rst), .SCLK(SCLK), .LAT(LAT), .SIN(SIN),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_data(cmd_data), .gs_index(gs_index),
        .fc_data(fc_data), .bit_err(bit_err), .seq_err(seq_err), .fc_err(fc_err), .cmd_err(cmd_err));

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    typedef struct {
        logic [3:0]  cmd;
        logic [47:0] data;
        logic [3:0]  gs;
        logic [47:0] fc;
        logic [3:0]  err;
    } exp_t;
    exp_t exp_q[$];

    logic [47:0] m_sr, m_fc;
    int          m_gs, m_idx;
    bit          m_fc_en, m_bit_err, m_seq_err, m_fc_err, m_cmd_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_sr = '0; m_fc = '0; m_gs = 0; m_idx = 0; m_fc_en = 0;
        m_bit_err = 0; m_seq_err = 0; m_fc_err = 0; m_cmd_err = 0;
        exp_q.delete();
    endtask

    // Word-level view: a command is n shifted bits, the last nlat of them with LAT high.
    task automatic model_cmd(input logic [63:0] d, input int n, input int nlat);
        exp_t e;
        int lc, bc;
        for (int i = 0; i < n; i++) m_sr = (m_sr << 1) | 48'(d[n-1-i]);
        lc = nlat > 15 ? 15 : nlat;
        bc = n > 63 ? 63 : n;
        if (!(lc % 2 == 1 && lc != 9)) m_cmd_err = 1;
        if ((lc == 1 || lc == 3 || lc == 5) && bc != 48) m_bit_err = 1;
        if (lc == 1) begin
            if (m_gs == 15) begin m_seq_err = 1; m_idx = 0; m_gs = 1; end
            else begin m_idx = m_gs; m_gs++; end
        end
        if (lc == 3) begin
            if (m_gs != 15) m_seq_err = 1;
            m_idx = 15; m_gs = 0;
        end
        if (lc == 7) m_gs = 0;
        if (lc == 5) begin
            if (m_fc_en) m_fc = m_sr;
            else m_fc_err = 1;
        end
        m_fc_en = lc == 15;
        e.cmd = 4'(lc); e.data = m_sr; e.gs = 4'(m_idx); e.fc = m_fc;
        e.err = {m_bit_err, m_seq_err, m_fc_err, m_cmd_err};
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [63:0] d, input int n, input int nlat, input bit sim);
        if (nlat > 0) model_cmd(d, n, nlat);
        for (int i = 0; i < n; i++) begin
            SIN = d[n-1-i];
            if (i >= n - nlat) LAT = 1'b1;
            repeat ($urandom_range(2, 3)) @(negedge clk);
            SCLK = 1'b1;
            if (sim && i == n - 1) LAT = 1'b0;
            repeat ($urandom_range(2, 3)) @(negedge clk);
            SCLK = 1'b0;
        end
        repeat (2) @(negedge clk);
        LAT = 1'b0;
        if (nlat > 0) begin
            for (int c = 0; c < 30 && exp_q.size() != 0; c++) @(negedge clk);
            if (exp_q.size() != 0) begin
                total++; bad++;
                $display("FAIL cmd_timeout: got no cmd_valid want cmd=%0d", exp_q[0].cmd);
                exp_q.delete();
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_idle();
        chk("rst_cmd_valid", 64'(cmd_valid), 0);
        chk("rst_cmd", 64'(cmd), 0);
        chk("rst_cmd_data", 64'(cmd_data), 0);
        chk("rst_gs_index", 64'(gs_index), 0);
        chk("rst_fc_data", 64'(fc_data), 0);
        chk("rst_errs", 64'({bit_err, seq_err, fc_err, cmd_err}), 0);
    endtask

    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (rst && cmd_valid) begin
            chk("pulse_width", 64'(prev_valid), 0);
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_cmd: got cmd=%0d want none", cmd);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("cmd", 64'(cmd), 64'(e.cmd));
                chk("cmd_data", 64'(cmd_data), 64'(e.data));
                chk("gs_index", 64'(gs_index), 64'(e.gs));
                chk("fc_data", 64'(fc_data), 64'(e.fc));
                chk("err_flags", 64'({bit_err, seq_err, fc_err, cmd_err}), 64'(e.err));
            end
        end
        prev_valid <= cmd_valid;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got hang want finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        int r, nl, n;
        model_reset();
        repeat (4) @(negedge clk);
        check_idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle();

        send(64'hA5A5_0000_FFFF, 48, 1, 0);
        for (int i = 0; i < 14; i++) send({$urandom, $urandom}, 48, 1, 0);
        send({$urandom, $urandom}, 48, 3, 0);
        send({$urandom, $urandom}, 48, 1, 0);
        send(64'h0, 7, 7, 0);

        for (int i = 0; i < 7; i++) send({$urandom, $urandom}, 48, 1, 0);
        send({$urandom, $urandom}, 48, 3, 0);
        send({$urandom, $urandom}, 48, 1, 0);

        send(64'h0, 15, 15, 0);
        send(64'h0000_0012_3456, 48, 5, 0);
        send(64'h1, 48, 5, 0);

        send({$urandom, $urandom}, 40, 1, 0);
        send(64'h0, 9, 9, 0);
        send(64'h0, 20, 20, 0);
        send({$urandom, $urandom}, 48, 1, 1);
        send({$urandom, $urandom}, 48, 3, 1);

        send({$urandom, $urandom}, 30, 0, 0);
        #3 rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle();
        send(64'hDEAD_BEEF_CAFE, 48, 1, 0);

        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 9);
            nl = r <= 3 ? 1 : r == 4 ? 3 : r == 5 ? 5 : r == 6 ? 15 : r == 7 ? 7 :
                 r == 8 ? ($urandom_range(0, 1) ? 11 : 13) : $urandom_range(1, 20);
            if (nl <= 5) n = $urandom_range(0, 4) == 0 ? $urandom_range(40, 56) : 48;
            else n = $urandom_range(nl, 30);
            d = {$urandom, $urandom};
            send(d, n, nl, $urandom_range(0, 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
